seq_slice_comparator: RTL and testbench
=======================================

Name: seq_slice_comparator

Overview:
Multi-cycle magnitude comparator that compares two W-bit operands two bits per clock, starting at the most-significant 2-bit slice. It keeps a running equal/less-than state across cycles, the same way a 2-bit compare-slice chain does. It adds a start/done handshake, a per-transaction signed/unsigned mode and optional early termination. Intended for area-constrained datapaths where a full-width combinational comparator is not wanted.

Parameters:
W, 8, operand width in bits; must be even and >= 2 (elaboration error otherwise)
EARLY_EXIT, 1, 1 = finish as soon as the first differing slice is found; 0 = always process all W/2 slices

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a comparison; sampled only in IDLE or DONE
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
A  input  W  operand A; sampled with start
B  input  W  operand B; sampled with start
busy  output  1  high while slices are being processed (RUN)
done  output  1  one-cycle pulse: results valid
EQ  output  1  registered result A == B
LT  output  1  registered result A < B
GT  output  1  registered result A > B

Behaviour:
- Single clock domain. rst is synchronous and active-high; it is the only reset.
- Reset values: state=IDLE, busy=0, done=0, EQ=1, LT=0, GT=0, internal eq_acc=1, lt_acc=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 latches A and B into shadow registers and goes to RUN. At that edge the latch sets idx=W/2-1, eq_acc=1, lt_acc=0.
  - When signed_mode=1, bit W-1 of both latched operands is inverted (offset-binary). The rest of the datapath is purely unsigned.
- RUN (busy=1), on each edge:
  - Compare slice s = {a[2idx+1], a[2idx]} against the matching B slice.
  - If eq_acc=1 and the slices differ: eq_acc<=0 and lt_acc<=(a_slice < b_slice).
  - Once eq_acc=0, it and lt_acc are frozen for the rest of the transaction.
  - Go to DONE if idx==0, or if EARLY_EXIT=1 and a difference was found on this edge. Otherwise idx<=idx-1.
- DONE (done=1 for this one cycle):
  - On entry, EQ<=eq_acc, LT<=lt_acc and GT<=!eq_acc & !lt_acc, all from the final compare edge.
  - Next edge: start=1 begins a new transaction back-to-back (same latch rules as IDLE). Otherwise go to IDLE.
- Latency, with start sampled on edge 0 and j = index of the first differing slice:
  - EARLY_EXIT=0: compares occur on edges 1..W/2; done is high in the cycle after edge W/2.
  - EARLY_EXIT=1: compares occur on edges 1..(W/2-j) and done follows edge W/2-j. Equal operands take the full W/2 edges.
- EQ, LT and GT hold their last values through IDLE and RUN. They change only on DONE entry and on reset. Exactly one of the three is 1 at all times.
- start while in RUN is ignored. Operand and mode inputs are ignored outside the start-sampling edge.
- rst asserted mid-RUN or in DONE aborts the transaction: no done pulse, and all outputs return to reset values on that edge.
- rst and start asserted together: rst wins.
- Boundary cases, all required to work:
  - W=2: a single-slice transaction, done after edge 1.
  - idx wrap: idx never decrements below 0, because DONE is taken at idx==0.

Test Plan:
- W=8, EARLY_EXIT=0, unsigned: A=0xA5, B=0xA5 -> done exactly 4 cycles after the start edge, EQ=1 LT=0 GT=0. busy high for 4 cycles, done high for 1 cycle.
- W=8, EARLY_EXIT=1, unsigned: A=0x40, B=0x80 -> MSB slice differs, done after edge 1, LT=1 EQ=0 GT=0. Then A=0x12, B=0x13 -> done after edge 4, LT=1.
- W=8, signed: A=0xFF (-1), B=0x01 -> LT=1. The same operands with signed_mode=0 -> GT=1. Also A=0x80, B=0x7F signed -> LT=1.
- Back-to-back: assert start in the DONE cycle with A=0x03, B=0x02 -> the new transaction starts with no IDLE cycle. The previous EQ/LT/GT hold until the new DONE, then GT=1.
- start pulsed during RUN with different operands -> ignored; the result reflects the original operands.
- Reset mid-RUN at edge 2 of a transaction -> no done pulse, and busy=0, EQ=1, LT=0, GT=0 after that edge. A subsequent start completes normally.

Source files
------------

// File: rtl/seq_slice_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : seq_slice_comparator
//  Description : Multi-cycle magnitude comparator. Compares two W-bit
//                operands two bits per clock, most-significant slice first,
//                carrying a running equal/less-than state between cycles.
//                Start/done handshake, per-transaction signed/unsigned mode,
//                optional early termination on the first differing slice.
//  Ports       : clk          rising-edge clock
//                rst          synchronous active-high reset
//                start        request a comparison (sampled in IDLE/DONE)
//                signed_mode  1 = two's-complement, 0 = unsigned
//                A, B         W-bit operands, sampled with start
//                busy         high while slices are processed
//                done         one-cycle pulse, results valid
//                EQ, LT, GT   registered, mutually exclusive results
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_slice_comparator #(
  parameter int W          = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         EQ,
  output logic         LT,
  output logic         GT
);

  generate
    if ((W < 2) || ((W % 2) != 0)) begin : g_bad_width
      $error("seq_slice_comparator: W must be even and >= 2");
    end
  endgenerate

  localparam int IW = (W / 2 > 1) ? $clog2(W / 2) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IW-1:0] IDX_TOP   = IW'(W / 2 - 1);
  localparam logic [W-1:0]  SIGN_MASK = {1'b1, {(W-1){1'b0}}};

  logic [1:0]    state;
  logic [1:0]    state_next;

  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [IW-1:0] idx;
  logic          eq_acc;
  logic          lt_acc;

  logic [IW:0]   shamt;
  logic [1:0]    a_slice;
  logic [1:0]    b_slice;
  logic          found;
  logic          eq_nxt;
  logic          lt_nxt;
  logic          last_slice;
  logic          load;

  // --------------------------------------------------------------------------
  // Slice compare: one 2-bit step of the compare chain. Once a difference has
  // been seen the accumulators stay frozen, so lower slices cannot override.
  // --------------------------------------------------------------------------
  always_comb begin
    shamt      = {idx, 1'b0};
    a_slice    = 2'(a_sh >> shamt);
    b_slice    = 2'(b_sh >> shamt);
    found      = eq_acc && (a_slice != b_slice);
    eq_nxt     = eq_acc & ~found;
    lt_nxt     = found ? (a_slice < b_slice) : lt_acc;
    last_slice = (idx == '0) || ((EARLY_EXIT != 0) && found);
    load       = start && ((state == ST_IDLE) || (state == ST_DONE));
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_slice) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // --------------------------------------------------------------------------
  // Datapath: operand shadows, slice index, accumulators, result registers.
  // Signed mode flips the MSB of both operands (offset binary) so the slice
  // chain itself only ever does unsigned comparisons.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      idx    <= '0;
      eq_acc <= 1'b1;
      lt_acc <= 1'b0;
      EQ     <= 1'b1;
      LT     <= 1'b0;
      GT     <= 1'b0;
    end else if (load) begin
      a_sh   <= A ^ (signed_mode ? SIGN_MASK : '0);
      b_sh   <= B ^ (signed_mode ? SIGN_MASK : '0);
      idx    <= IDX_TOP;
      eq_acc <= 1'b1;
      lt_acc <= 1'b0;
    end else if (state == ST_RUN) begin
      eq_acc <= eq_nxt;
      lt_acc <= lt_nxt;
      if (last_slice) begin
        // Results come from this final compare edge, not the stale accumulators.
        EQ <= eq_nxt;
        LT <= lt_nxt;
        GT <= ~eq_nxt & ~lt_nxt;
      end else begin
        idx <= idx - IW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_slice_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_slice_comparator
//  Description : Self-checking bench for seq_slice_comparator. Three DUTs:
//                W=8 full-scan, W=8 early-exit, W=2 early-exit. Expected
//                values come from integer arithmetic on the operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_slice_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] start_v;
  logic [2:0] sm_v;
  logic [7:0] a_v [3];
  logic [7:0] b_v [3];

  logic busy0, done0, eq0, lt0, gt0;
  logic busy1, done1, eq1, lt1, gt1;
  logic busy2, done2, eq2, lt2, gt2;

  int tests = 0;
  int fails = 0;

  seq_slice_comparator #(.W(8), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .signed_mode(sm_v[0]),
    .A(a_v[0]), .B(b_v[0]),
    .busy(busy0), .done(done0), .EQ(eq0), .LT(lt0), .GT(gt0)
  );

  seq_slice_comparator #(.W(8), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .signed_mode(sm_v[1]),
    .A(a_v[1]), .B(b_v[1]),
    .busy(busy1), .done(done1), .EQ(eq1), .LT(lt1), .GT(gt1)
  );

  seq_slice_comparator #(.W(2), .EARLY_EXIT(1)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .signed_mode(sm_v[2]),
    .A(a_v[2][1:0]), .B(b_v[2][1:0]),
    .busy(busy2), .done(done2), .EQ(eq2), .LT(lt2), .GT(gt2)
  );

  // {busy, done, EQ, LT, GT}
  function automatic logic [4:0] obs(input int d);
    case (d)
      0:       return {busy0, done0, eq0, lt0, gt0};
      1:       return {busy1, done1, eq1, lt1, gt1};
      default: return {busy2, done2, eq2, lt2, gt2};
    endcase
  endfunction

  // Reference: {EQ, LT, GT} from the numeric values of the operands.
  function automatic logic [2:0] exp_res(input int w, input logic [7:0] a,
                                         input logic [7:0] b, input logic sm);
    int va, vb;
    va = int'(a) & ((1 << w) - 1);
    vb = int'(b) & ((1 << w) - 1);
    if (sm && (((va >> (w - 1)) & 1) != 0)) va = va - (1 << w);
    if (sm && (((vb >> (w - 1)) & 1) != 0)) vb = vb - (1 << w);
    if (va == vb) return 3'b100;
    if (va < vb)  return 3'b010;
    return 3'b001;
  endfunction

  // Reference: number of compare edges before done.
  function automatic int exp_lat(input int w, input int ee, input logic [7:0] a,
                                 input logic [7:0] b);
    int x, h;
    x = int'(a ^ b) & ((1 << w) - 1);
    if (x == 0 || ee == 0) return w / 2;
    h = 0;
    for (int i = 0; i < w; i++) if (((x >> i) & 1) != 0) h = i;
    return w / 2 - h / 2;
  endfunction

  // Drive one transaction on DUT d; inputs are scrambled after the start edge.
  // lat = index m of the edge after which done is seen (-1 on timeout).
  task automatic run_txn(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic sm, output int lat, output int bcnt,
                         output logic [2:0] res);
    logic [4:0] o;
    @(negedge clk);
    start_v[d] = 1'b1; sm_v[d] = sm; a_v[d] = a; b_v[d] = b;
    lat = -1; bcnt = 0; res = 3'b000;
    @(posedge clk);
    for (int m = 0; m < 40; m++) begin
      @(negedge clk);
      if (m == 0) begin
        start_v[d] = 1'b0;
        a_v[d] = 8'($urandom); b_v[d] = 8'($urandom); sm_v[d] = 1'($urandom);
      end
      o = obs(d);
      if (o[4]) bcnt++;
      if (o[3]) begin
        lat = m; res = o[2:0];
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [4:0] o;
    for (int d = 0; d < 3; d++) begin
      o = obs(d);
      tests++;
      if (o !== 5'b00100) begin
        fails++;
        $display("FAIL reset_state dut%0d: got %b expected 00100", d, o);
      end
    end
  endtask

  task automatic test_equal_full();
    int lat, bcnt; logic [2:0] res;
    run_txn(0, 8'hA5, 8'hA5, 1'b0, lat, bcnt, res);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL eq_full_latency: got %0d expected 4", lat); end
    tests++;
    if (bcnt !== 4) begin fails++; $display("FAIL eq_full_busy: got %0d expected 4", bcnt); end
    tests++;
    if (res !== 3'b100) begin fails++; $display("FAIL eq_full_result: got %b expected 100", res); end
    @(negedge clk);
    tests++;
    if (done0 !== 1'b0) begin fails++; $display("FAIL eq_full_done_pulse: got %b expected 0", done0); end
  endtask

  task automatic test_early_exit();
    int lat, bcnt; logic [2:0] res;
    run_txn(1, 8'h40, 8'h80, 1'b0, lat, bcnt, res);
    tests++;
    if (lat !== 1 || res !== 3'b010) begin
      fails++; $display("FAIL early_msb: got lat=%0d res=%b expected lat=1 res=010", lat, res);
    end
    run_txn(1, 8'h12, 8'h13, 1'b0, lat, bcnt, res);
    tests++;
    if (lat !== 4 || res !== 3'b010) begin
      fails++; $display("FAIL early_lsb: got lat=%0d res=%b expected lat=4 res=010", lat, res);
    end
  endtask

  task automatic test_signed();
    int lat, bcnt; logic [2:0] res;
    run_txn(1, 8'hFF, 8'h01, 1'b1, lat, bcnt, res);
    tests++;
    if (res !== 3'b010) begin fails++; $display("FAIL signed_m1_vs_1: got %b expected 010", res); end
    run_txn(1, 8'hFF, 8'h01, 1'b0, lat, bcnt, res);
    tests++;
    if (res !== 3'b001) begin fails++; $display("FAIL unsigned_ff_vs_1: got %b expected 001", res); end
    run_txn(1, 8'h80, 8'h7F, 1'b1, lat, bcnt, res);
    tests++;
    if (res !== 3'b010 || lat !== 1) begin
      fails++; $display("FAIL signed_80_vs_7f: got res=%b lat=%0d expected res=010 lat=1", res, lat);
    end
  endtask

  task automatic test_w2();
    int lat, bcnt; logic [2:0] res;
    logic [2:0] e;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a, b; logic sm;
      a = 8'(i & 3); b = 8'((i * 3 + 1) & 3); sm = 1'(i >> 2);
      e = exp_res(2, a, b, sm);
      run_txn(2, a, b, sm, lat, bcnt, res);
      tests++;
      if (lat !== 1 || res !== e) begin
        fails++;
        $display("FAIL w2 a=%0d b=%0d s=%0d: got lat=%0d res=%b expected lat=1 res=%b",
                 a, b, sm, lat, res, e);
      end
    end
  endtask

  task automatic test_random();
    int lat, bcnt, w, ee, el; logic [2:0] res, e;
    for (int n = 0; n < 45; n++) begin
      int d; logic [7:0] a, b; logic sm;
      d = n % 3;
      w = (d == 2) ? 2 : 8;
      ee = (d == 0) ? 0 : 1;
      a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
      if ($urandom_range(0, 3) == 0) b = a;
      else if ($urandom_range(0, 2) == 0) b = a ^ 8'(1 << $urandom_range(0, 7));
      e = exp_res(w, a, b, sm);
      el = exp_lat(w, ee, a, b);
      run_txn(d, a, b, sm, lat, bcnt, res);
      tests++;
      if (lat !== el || res !== e || bcnt !== el) begin
        fails++;
        $display("FAIL random dut%0d a=%h b=%h s=%0d: got lat=%0d busy=%0d res=%b expected lat=%0d res=%b",
                 d, a, b, sm, lat, bcnt, res, el, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt; logic [2:0] res;
    run_txn(1, 8'h05, 8'h09, 1'b0, lat, bcnt, res);
    tests++;
    if (lat !== 3 || res !== 3'b010) begin
      fails++; $display("FAIL b2b_first: got lat=%0d res=%b expected lat=3 res=010", lat, res);
    end
    // Still in the DONE cycle: request the next transaction immediately.
    start_v[1] = 1'b1; a_v[1] = 8'h03; b_v[1] = 8'h02; sm_v[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_v[1] = 1'b0; a_v[1] = 8'h00; b_v[1] = 8'hFF;
    tests++;
    if ({busy1, done1, eq1, lt1, gt1} !== 5'b10010) begin
      fails++; $display("FAIL b2b_no_idle: got %b expected 10010", {busy1, done1, eq1, lt1, gt1});
    end
    lat = -1;
    for (int m = 1; m < 20; m++) begin
      @(negedge clk);
      if (done1) begin lat = m; break; end
      tests++;
      if ({eq1, lt1, gt1} !== 3'b010) begin
        fails++; $display("FAIL b2b_hold m=%0d: got %b expected 010", m, {eq1, lt1, gt1});
      end
    end
    tests++;
    if (lat !== 4 || {eq1, lt1, gt1} !== 3'b001) begin
      fails++; $display("FAIL b2b_second: got lat=%0d res=%b expected lat=4 res=001", lat, {eq1, lt1, gt1});
    end
  endtask

  task automatic test_start_during_run();
    int lat;
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 8'h10; b_v[0] = 8'h20; sm_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 8'h30; b_v[0] = 8'h00;
    @(negedge clk);
    start_v[0] = 1'b0;
    lat = -1;
    for (int m = 3; m < 20; m++) begin
      @(negedge clk);
      if (done0) begin lat = m; break; end
    end
    tests++;
    if (lat !== 4 || {eq0, lt0, gt0} !== 3'b010) begin
      fails++; $display("FAIL start_in_run: got lat=%0d res=%b expected lat=4 res=010", lat, {eq0, lt0, gt0});
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bcnt, seen; logic [2:0] res;
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 8'h90; b_v[0] = 8'h11; sm_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy0, done0, eq0, lt0, gt0} !== 5'b00100) begin
      fails++; $display("FAIL reset_mid_run: got %b expected 00100", {busy0, done0, eq0, lt0, gt0});
    end
    rst = 1'b0;
    seen = 0;
    for (int m = 0; m < 6; m++) begin
      @(negedge clk);
      if (done0 || busy0) seen++;
    end
    tests++;
    if (seen !== 0) begin fails++; $display("FAIL reset_no_done: got %0d active cycles expected 0", seen); end
    run_txn(0, 8'h90, 8'h11, 1'b0, lat, bcnt, res);
    tests++;
    if (lat !== 4 || res !== 3'b001) begin
      fails++; $display("FAIL after_reset: got lat=%0d res=%b expected lat=4 res=001", lat, res);
    end
  endtask

  initial begin
    start_v = '0; sm_v = '0;
    for (int d = 0; d < 3; d++) begin a_v[d] = '0; b_v[d] = '0; end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_equal_full();
    test_early_exit();
    test_signed();
    test_w2();
    test_random();
    test_back_to_back();
    test_start_during_run();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
